scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with two modes.
- Direct mode: decodes the SEL input, registered.
- Scan mode: steps the active output through all positions automatically, holding each for DWELL cycles. Intended for display digit or row strobing.
- Sits between control logic and multiplexed output drivers.
- Provides the current index and a once-per-cycle wrap pulse for the data path that feeds each position.

Parameters:
- SEL_W, 3, index width; number of outputs OUT_W = 2**SEL_W (derived, not overridable).
- DWELL, 4, clock cycles each position is held in scan mode; legal range 1..65535.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- EN  input  1  advance enable; when low, all state holds.
- MODE  input  1  0 = direct decode of SEL, 1 = auto scan.
- SEL  input  SEL_W  index to decode in direct mode; ignored in scan mode.
- O  output  OUT_W  registered one-hot output; bit IDX is high.
- IDX  output  SEL_W  registered index currently driven on O.
- WRAP  output  1  one-cycle pulse when the scan index rolls from OUT_W-1 to 0.

Behaviour:
- Clocking and reset:
  - One clock (CLK). Reset is synchronous and active-high (RST); RST has priority over every other input.
  - Reset values: O = 1 (bit 0 only), IDX = 0, WRAP = 0, internal dwell counter CNT = 0.
- Invariants:
  - O == (1 << IDX) on every cycle, including reset.
  - O is never all-zero and never has more than one bit set.
- CNT width = max(1, clog2(DWELL)). CNT counts 0..DWELL-1 and never exceeds DWELL-1.
- EN = 0: O, IDX and CNT hold. WRAP = 0. The MODE and SEL values are ignored that cycle.
- Direct mode (EN = 1, MODE = 0):
  - Latency 1 cycle: the SEL sampled at edge k appears on IDX/O after edge k.
  - CNT is cleared to 0. WRAP = 0.
- Scan mode (EN = 1, MODE = 1):
  - If CNT < DWELL-1: CNT increments; IDX/O hold.
  - If CNT == DWELL-1: CNT <= 0; IDX <= (IDX + 1) mod OUT_W; O follows.
  - WRAP is registered. It is 1 for exactly the cycle in which IDX first shows 0 after a roll from OUT_W-1; otherwise 0.
  - DWELL = 1: IDX advances on every enabled cycle. WRAP fires once every OUT_W enabled cycles.
- Mode transitions:
  - Direct -> scan: scanning starts from the current IDX with CNT = 0, so the current position gets a full DWELL before its first advance.
  - Scan -> direct: the next enabled edge loads SEL regardless of CNT. A partial dwell is discarded.
- The index wrap is natural modulo-2^SEL_W arithmetic; there are no unused codes.
- Reset mid-scan (any CNT, any IDX): next cycle O = 1, IDX = 0, CNT = 0, WRAP = 0. A pending wrap is not emitted.
- The block has no combinational path from any input to any output.

Test Plan:
- Reset: hold RST 2 cycles with EN = 1, MODE = 1 -> O = 8'b00000001, IDX = 0, WRAP = 0. Release -> first advance after exactly 4 enabled cycles.
- Direct mode (SEL_W = 3): drive SEL = 0..7, one per cycle, EN = 1, MODE = 0 -> O = 8'b00000001, 8'b00000010, ... 8'b10000000, each one cycle after SEL. IDX equals the previous SEL. Check one-hot every cycle.
- Scan timing (DWELL = 4): MODE = 1, EN = 1 for 40 cycles -> IDX steps 0,1,...,7,0 every 4 cycles. WRAP high for exactly 1 cycle, at cycle 32 after reset release, coincident with IDX = 0.
- EN hold: in scan mode, drop EN for 5 cycles when CNT = 2, IDX = 5 -> O stays 8'b00100000 throughout. After re-enable, advance to IDX = 6 occurs 2 enabled cycles later.
- Mode switch: scan at IDX = 3, CNT = 2, switch MODE = 0 with SEL = 6 -> next cycle IDX = 6, O = 8'b01000000. Switch back to MODE = 1 -> IDX = 7 after 4 enabled cycles.
- DWELL = 1, SEL_W = 2 build, plus reset mid-scan: IDX cycles 0,1,2,3,0 every cycle; WRAP every 4th cycle. Assert RST at IDX = 2 -> next cycle O = 4'b0001, WRAP = 0.

Source files
------------

// File: rtl/scan_decoder.sv
// Registered one-hot decoder: direct decode of sel, or an auto-scan that holds
// each position for DWELL enabled cycles and pulses wrap on the roll to zero.
module scan_decoder #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned DWELL = 4,
  localparam int unsigned OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] o,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [SEL_W-1:0] idx_n;
  logic [OUT_W-1:0] o_n;
  logic             wrap_n;

  // State register; o is stored rather than decoded so it leaves a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      o    <= OUT_W'(1);
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      idx  <= idx_n;
      o    <= o_n;
      wrap <= wrap_n;
    end
  end

  // Next index / dwell count; a direct cycle discards any partial dwell.
  always_comb begin
    cnt_n  = cnt;
    idx_n  = idx;
    wrap_n = 1'b0;
    if (en) begin
      if (!mode) begin
        idx_n = sel;
        cnt_n = '0;
      end else if (cnt == CNT_LAST) begin
        cnt_n  = '0;
        idx_n  = idx + SEL_W'(1);
        wrap_n = &idx;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
    o_n = OUT_W'(1) << idx_n;
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: a (SEL_W=3, DWELL=4) and a (SEL_W=2, DWELL=1) build
// checked each cycle against a position-count model plus literal checkpoints.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [2:0] sel;
  logic [1:0] sel_b;

  logic [7:0] o_a;
  logic [2:0] idx_a;
  logic       wrap_a;
  logic [3:0] o_b;
  logic [1:0] idx_b;
  logic       wrap_b;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: start index plus enabled scan cycles since scanning began.
  int base_a, steps_a, base_b, steps_b;
  bit wexp_a, wexp_b;

  always #5 clk = ~clk;

  assign sel_b = sel[1:0];

  scan_decoder #(.SEL_W(3), .DWELL(4)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .o(o_a), .idx(idx_a), .wrap(wrap_a)
  );

  scan_decoder #(.SEL_W(2), .DWELL(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_b),
    .o(o_b), .idx(idx_b), .wrap(wrap_b)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input int d, input int n, input int s,
                       inout int base, inout int steps, inout bit wexp);
    if (rst) begin
      base = 0; steps = 0; wexp = 0;
    end else if (!en) begin
      wexp = 0;
    end else if (!mode) begin
      base = s; steps = 0; wexp = 0;
    end else begin
      steps++;
      wexp = (steps % d == 0) && (((base + steps / d) % n) == 0);
      if (steps == d * n) steps = 0;
    end
  endtask

  // One clock: advance the model with the applied inputs, then compare outputs.
  task automatic step();
    int ia, ib;
    @(posedge clk);
    model(4, 8, int'(sel), base_a, steps_a, wexp_a);
    model(1, 4, int'(sel_b), base_b, steps_b, wexp_b);
    #1;
    ia = (base_a + steps_a / 4) % 8;
    ib = (base_b + steps_b) % 4;
    check("a_idx", idx_a, ia);
    check("a_o", o_a, 1 << ia);
    check("a_wrap", wrap_a, wexp_a);
    check("b_idx", idx_b, ib);
    check("b_o", o_b, 1 << ib);
    check("b_wrap", wrap_b, wexp_b);
  endtask

  task automatic steps_n(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    base_a = 0; steps_a = 0; base_b = 0; steps_b = 0; wexp_a = 0; wexp_b = 0;
    rst = 1; en = 1; mode = 1; sel = 0;

    // Reset held while scan-enabled.
    steps_n(2);
    check("rst_o_a", o_a, 8'b0000_0001);
    check("rst_idx_a", idx_a, 0);
    check("rst_wrap_a", wrap_a, 0);
    check("rst_o_b", o_b, 4'b0001);

    // Scan timing from release.
    rst = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 3)  check("scan_hold3", idx_a, 0);
      if (i == 4)  check("scan_adv4", idx_a, 1);
      if (i == 4)  check("b_wrap4", wrap_b, 1);
      if (i == 31) check("scan_nowrap31", wrap_a, 0);
      if (i == 32) check("scan_wrap32", wrap_a, 1);
      if (i == 32) check("scan_idx32", idx_a, 0);
      if (i == 33) check("scan_wrap33", wrap_a, 0);
    end

    // Direct decode, one cycle latency.
    mode = 0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step();
      check("dir_o", o_a, 1 << s);
      check("dir_idx", idx_a, s);
    end

    // EN hold at idx 5, cnt 2.
    rst = 1; mode = 1; step();
    rst = 0; steps_n(22);
    check("hold_start", idx_a, 5);
    en = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_o", o_a, 8'b0010_0000);
    end
    en = 1;
    step(); check("hold_resume1", idx_a, 5);
    step(); check("hold_resume2", idx_a, 6);

    // Scan -> direct -> scan.
    rst = 1; step();
    rst = 0; steps_n(14);
    check("sw_start", idx_a, 3);
    mode = 0; sel = 3'd6; step();
    check("sw_idx", idx_a, 6);
    check("sw_o", o_a, 8'b0100_0000);
    mode = 1; steps_n(3);
    check("sw_hold", idx_a, 6);
    step(); check("sw_adv", idx_a, 7);

    // Reset mid-scan on the DWELL=1 build.
    rst = 1; step();
    rst = 0; steps_n(2);
    check("b_mid_idx", idx_b, 2);
    rst = 1; step();
    check("b_rst_o", o_b, 4'b0001);
    check("b_rst_wrap", wrap_b, 0);
    rst = 0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 29) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = ($urandom_range(0, 2) != 0);
      sel  = 3'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
